// File: rtl/lbist_pkg.sv
// Shared types and constants for the c432 logic-BIST controller.
// Contents:
//   state_e       controller states (IDLE, INIT, RUN, COMPARE, DONE)
//   CUT_IN_W      pattern width driven onto the CUT (36)
//   CUT_OUT_W     CUT response width (7)
//   MISR_W        signature width (16)
//   LFSR_TAP_HI/LO feedback taps of the pattern generator (35/24)
//   MISR_POLY_DEF default Galois feedback polynomial x^16+x^5+x^3+x^2+1
//   lfsr_next()   one step of the pattern-generator LFSR
package lbist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    RUN     = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int CUT_IN_W    = 36;
  localparam int CUT_OUT_W   = 7;
  localparam int MISR_W      = 16;
  localparam int LFSR_TAP_HI = 35;
  localparam int LFSR_TAP_LO = 24;

  localparam logic [MISR_W-1:0] MISR_POLY_DEF = 16'h002D;

  // Left shift with XNOR-free feedback; the map is invertible, so a
  // non-zero state can never step into all-zero.
  function automatic logic [CUT_IN_W-1:0] lfsr_next(input logic [CUT_IN_W-1:0] v);
    return {v[CUT_IN_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/lbist_misr.sv
// Galois multiple-input signature register.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         synchronous clear (priority over en)
//   en          absorb data this cycle
//   data        parallel input folded into the signature
//   sig         current signature
module lbist_misr #(
  parameter int             W    = 16,
  parameter logic [W-1:0]   POLY = 16'h002D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/lbist_ctrl_c432.sv
// Logic-BIST controller for the c432 combinational CUT: a 36-bit LFSR
// drives patterns onto the CUT, a 16-bit MISR compacts the responses over
// PAT_COUNT patterns and the result is compared to GOLDEN_SIG.
// Build option: define LBIST_ABORT_EN to add the abort input.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       session request, honoured only in IDLE or DONE
//   abort       (LBIST_ABORT_EN only) end session early with pass=0
//   cut_in      pattern to the CUT, zero outside RUN
//   cut_out     CUT response, sampled in the same cycle as cut_in
//   busy        high in INIT, RUN, COMPARE
//   done        high in DONE until the next start
//   pass        compare result, meaningful while done=1
//   signature   MISR contents, frozen once DONE is reached
//   pat_cnt     patterns applied so far
//   dbg_state   current FSM state (state_e encoding)
// Handshake: start is a level sampled on each rising edge; in IDLE or DONE
// a high sample launches a session, in every other state it is ignored.
module lbist_ctrl_c432
  import lbist_pkg::*;
#(
  parameter int unsigned         PAT_COUNT  = 1024,
  parameter logic [CUT_IN_W-1:0] LFSR_SEED  = 36'h0_0000_0001,
  parameter logic [MISR_W-1:0]   MISR_POLY  = MISR_POLY_DEF,
  parameter logic [MISR_W-1:0]   GOLDEN_SIG = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef LBIST_ABORT_EN
  input  logic                 abort,
`endif
  output logic [CUT_IN_W-1:0]  cut_in,
  input  logic [CUT_OUT_W-1:0] cut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [MISR_W-1:0]    signature,
  output logic [15:0]          pat_cnt,
  output logic [2:0]           dbg_state
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [CUT_IN_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? 36'h1 : LFSR_SEED;
  localparam logic [15:0]         LAST_CNT = 16'(PAT_COUNT - 1);

  state_e              state_q, state_d;
  logic [CUT_IN_W-1:0] lfsr_q, lfsr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                pass_q, pass_d;
  logic                misr_clr, misr_en;
  logic [MISR_W-1:0]   misr_sig;
  logic                abort_w;
  logic                active;

`ifdef LBIST_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign active = (state_q == INIT) || (state_q == RUN) || (state_q == COMPARE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides the normal RUN exit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = RUN;
      RUN:     if (cnt_q == LAST_CNT) state_d = COMPARE;
      COMPARE: state_d = DONE;
      DONE:    if (start) state_d = INIT;
      default: state_d = IDLE;
    endcase
    if (abort_w && active) state_d = DONE;
  end

  // Outputs and datapath next values
  always_comb begin
    busy     = active;
    done     = (state_q == DONE);
    cut_in   = (state_q == RUN) ? lfsr_q : '0;
    misr_clr = (state_q == INIT) && !abort_w;
    misr_en  = (state_q == RUN) && !abort_w;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    if ((state_q == IDLE || state_q == DONE) && start) pass_d = 1'b0;
    if (state_q == INIT && !abort_w) begin
      lfsr_d = SEED_EFF;
      cnt_d  = '0;
    end
    if (state_q == RUN && !abort_w) begin
      lfsr_d = lfsr_next(lfsr_q);
      cnt_d  = cnt_q + 16'd1;
    end
    if (state_q == COMPARE) pass_d = (misr_sig == GOLDEN_SIG);
    if (abort_w && active)  pass_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_EFF;
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      pass_q <= pass_d;
    end
  end

  lbist_misr #(
    .W    (MISR_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr),
    .en    (misr_en),
    .data  ({{(MISR_W-CUT_OUT_W){1'b0}}, cut_out}),
    .sig   (misr_sig)
  );

  assign pass      = pass_q;
  assign signature = misr_sig;
  assign pat_cnt   = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lbist_ctrl_c432.sv
module tb_lbist_ctrl_c432;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_s = 1'b0;
  logic start_c = 1'b0;
  logic [6:0] cut_out_s = 7'h00;
  logic [6:0] cut_out_c;
`ifdef LBIST_ABORT_EN
  logic abort = 1'b0;
`endif

  logic [35:0] cut_in_a, cut_in_b, cut_in_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic [15:0] sig_a, sig_b, sig_c, cnt_a, cnt_b, cnt_c;
  logic [2:0] st_a, st_b, st_c;

  int checks = 0;
  int passed = 0;
  logic [15:0] exp_full;
  logic [15:0] exp_abort5;

  always #5 clk = ~clk;

  // Stand-in for the c432 netlist: a fixed combinational mix of all inputs.
  function automatic logic [6:0] cut_model(input logic [35:0] x);
    logic [6:0] r;
    r[0] = ^x[8:0];
    r[1] = ^x[17:9];
    r[2] = (x[18] & x[19]) ^ x[35];
    r[3] = |x[27:20];
    r[4] = ~(x[28] & x[29] & x[30]);
    r[5] = x[31] ^ x[0] ^ x[24];
    r[6] = (x[32] | x[33]) & ~x[34];
    return r;
  endfunction

  // Reference signature after n patterns with seed 1 through cut_model.
  function automatic logic [15:0] model_sig(input int n);
    logic [35:0] l;
    logic [15:0] m;
    l = 36'h1;
    m = 16'h0;
    for (int i = 0; i < n; i++) begin
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h002D : 16'h0000) ^ {9'b0, cut_model(l)};
      l = {l[34:0], l[35] ^ l[24]};
    end
    return m;
  endfunction

  assign cut_out_c = cut_model(cut_in_c);

  lbist_ctrl_c432 #(.PAT_COUNT(4), .LFSR_SEED(36'h1), .GOLDEN_SIG(16'h0000)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_s),
`ifdef LBIST_ABORT_EN
    .abort(abort),
`endif
    .cut_in(cut_in_a), .cut_out(cut_out_s), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .pat_cnt(cnt_a), .dbg_state(st_a));

  lbist_ctrl_c432 #(.PAT_COUNT(4), .LFSR_SEED(36'h1), .GOLDEN_SIG(16'h000F)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_s),
`ifdef LBIST_ABORT_EN
    .abort(abort),
`endif
    .cut_in(cut_in_b), .cut_out(cut_out_s), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .pat_cnt(cnt_b), .dbg_state(st_b));

  lbist_ctrl_c432 #(.PAT_COUNT(1024), .LFSR_SEED(36'h0), .GOLDEN_SIG(16'h0000)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c),
`ifdef LBIST_ABORT_EN
    .abort(abort),
`endif
    .cut_in(cut_in_c), .cut_out(cut_out_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .signature(sig_c), .pat_cnt(cnt_c), .dbg_state(st_c));

  task automatic test_reset();
    rst_n = 1'b0; start_s = 1'b1; start_c = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy_a, done_a, pass_a} !== 3'b000) $display("FAIL rst_flags_a: got %b want 000", {busy_a, done_a, pass_a}); else passed++;
    checks++; if (cut_in_a !== 36'h0) $display("FAIL rst_cut_in_a: got %h want 0", cut_in_a); else passed++;
    checks++; if ({sig_c, cnt_c} !== 32'h0) $display("FAIL rst_sig_cnt_c: got %h want 0", {sig_c, cnt_c}); else passed++;
    checks++; if (st_c !== 3'd0) $display("FAIL rst_state_c: got %0d want 0", st_c); else passed++;
    start_s = 1'b0; start_c = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({st_a, st_c} !== 6'd0) $display("FAIL idle_after_rst: got %0d/%0d want 0/0", st_a, st_c); else passed++;
    checks++; if ({busy_c, cnt_c} !== 17'd0) $display("FAIL idle_no_activity: got %b/%0d want 0/0", busy_c, cnt_c); else passed++;
  endtask

  task automatic test_small(input logic [6:0] cv, input logic [15:0] fin_sig, input logic pa, input logic pb);
    logic [15:0] m;
    m = 16'h0;
    cut_out_s = cv;
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    // cycle 1: INIT
    checks++; if (st_a !== 3'd1) $display("FAIL init_state: got %0d want 1", st_a); else passed++;
    checks++; if ({busy_a, done_a, pass_a, done_b} !== 4'b1000) $display("FAIL init_flags: got %b want 1000", {busy_a, done_a, pass_a, done_b}); else passed++;
    checks++; if (cut_in_a !== 36'h0) $display("FAIL init_cut_in: got %h want 0", cut_in_a); else passed++;
    // cycles 2..5: RUN; a start pulse in cycle 3 must be ignored
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start_s = (k == 1);
      checks++; if (st_a !== 3'd2) $display("FAIL run_state_%0d: got %0d want 2", k, st_a); else passed++;
      checks++; if (cut_in_a !== (36'd1 << k)) $display("FAIL run_cut_in_%0d: got %h want %h", k, cut_in_a, 36'd1 << k); else passed++;
      checks++; if (sig_a !== m) $display("FAIL run_sig_%0d: got %h want %h", k, sig_a, m); else passed++;
      checks++; if (cnt_a !== 16'(k)) $display("FAIL run_cnt_%0d: got %0d want %0d", k, cnt_a, k); else passed++;
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h002D : 16'h0000) ^ {9'b0, cv};
    end
    @(negedge clk) start_s = 1'b0;
    // cycle 6: COMPARE
    checks++; if ({st_a, busy_a, done_a} !== {3'd3, 2'b10}) $display("FAIL cmp_state: got %0d/%b%b want 3/10", st_a, busy_a, done_a); else passed++;
    checks++; if (cut_in_a !== 36'h0) $display("FAIL cmp_cut_in: got %h want 0", cut_in_a); else passed++;
    // cycle 7: DONE
    @(negedge clk);
    checks++; if ({done_a, done_b, busy_a} !== 3'b110) $display("FAIL done_flags: got %b want 110", {done_a, done_b, busy_a}); else passed++;
    checks++; if (sig_a !== fin_sig || sig_b !== fin_sig) $display("FAIL done_sig: got %h/%h want %h", sig_a, sig_b, fin_sig); else passed++;
    checks++; if (pass_a !== pa) $display("FAIL done_pass_a: got %b want %b", pass_a, pa); else passed++;
    checks++; if (pass_b !== pb) $display("FAIL done_pass_b: got %b want %b", pass_b, pb); else passed++;
    checks++; if (cnt_a !== 16'd4) $display("FAIL done_cnt: got %0d want 4", cnt_a); else passed++;
    repeat (3) @(negedge clk);
    checks++; if ({done_a, pass_a, sig_a} !== {1'b1, pa, fin_sig}) $display("FAIL done_hold: got %b%b %h want 1%b %h", done_a, pass_a, sig_a, pa, fin_sig); else passed++;
  endtask

  // Launch a session on dut_c and wait for done; cyc is the cycle done was seen.
  task automatic run_c(output int cyc);
    @(negedge clk) start_c = 1'b1;
    @(negedge clk) start_c = 1'b0;
    cyc = 1;
    while (!done_c && cyc < 1100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_full_run();
    int cyc;
    run_c(cyc);
    checks++; if (cyc !== 1027) $display("FAIL full_latency: got %0d want 1027", cyc); else passed++;
    checks++; if (sig_c !== exp_full) $display("FAIL full_sig: got %h want %h", sig_c, exp_full); else passed++;
    checks++; if (cnt_c !== 16'd1024) $display("FAIL full_cnt: got %0d want 1024", cnt_c); else passed++;
    checks++; if (pass_c !== (exp_full == 16'h0)) $display("FAIL full_pass: got %b want %b", pass_c, exp_full == 16'h0); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk) start_c = 1'b1;
    @(negedge clk) start_c = 1'b0;
    checks++; if ({st_c, busy_c, done_c, pass_c} !== {3'd1, 3'b100}) $display("FAIL b2b_init: got %0d/%b want 1/100", st_c, {busy_c, done_c, pass_c}); else passed++;
    cyc = 1;
    while (!done_c && cyc < 1100) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 1027) $display("FAIL b2b_latency: got %0d want 1027", cyc); else passed++;
    checks++; if (sig_c !== exp_full) $display("FAIL b2b_sig: got %h want %h", sig_c, exp_full); else passed++;
    checks++; if (cnt_c !== 16'd1024) $display("FAIL b2b_cnt: got %0d want 1024", cnt_c); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int w;
    @(negedge clk) start_c = 1'b1;
    @(negedge clk) start_c = 1'b0;
    w = 0;
    while (cnt_c !== 16'd10 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++; if (cnt_c !== 16'd10) $display("FAIL mid_reach10: got %0d want 10", cnt_c); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy_c, done_c, pass_c, st_c} !== 6'd0) $display("FAIL mid_rst_flags: got %b want 000000", {busy_c, done_c, pass_c, st_c}); else passed++;
    checks++; if ({cut_in_c, sig_c, cnt_c} !== 68'h0) $display("FAIL mid_rst_data: got %h/%h/%0d want 0", cut_in_c, sig_c, cnt_c); else passed++;
    @(negedge clk) rst_n = 1'b1;
    run_c(cyc);
    checks++; if (cyc !== 1027) $display("FAIL mid_rerun_latency: got %0d want 1027", cyc); else passed++;
    checks++; if (sig_c !== exp_full) $display("FAIL mid_rerun_sig: got %h want %h", sig_c, exp_full); else passed++;
  endtask

`ifdef LBIST_ABORT_EN
  task automatic test_abort();
    int w;
    @(negedge clk) start_c = 1'b1;
    @(negedge clk) start_c = 1'b0;
    w = 0;
    while (cnt_c !== 16'd5 && w < 100) begin
      @(negedge clk);
      w++;
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++; if ({done_c, busy_c, pass_c} !== 3'b100) $display("FAIL abort_flags: got %b want 100", {done_c, busy_c, pass_c}); else passed++;
    checks++; if (cnt_c !== 16'd5) $display("FAIL abort_cnt: got %0d want 5", cnt_c); else passed++;
    checks++; if (sig_c !== exp_abort5) $display("FAIL abort_sig: got %h want %h", sig_c, exp_abort5); else passed++;
    repeat (2) @(negedge clk);
    checks++; if ({st_c, cnt_c} !== {3'd4, 16'd5}) $display("FAIL abort_hold: got %0d/%0d want 4/5", st_c, cnt_c); else passed++;
  endtask
`endif

  initial begin
    exp_full   = model_sig(1024);
    exp_abort5 = model_sig(5);
    test_reset();
    test_small(7'h00, 16'h0000, 1'b1, 1'b0);
    test_small(7'h01, 16'h000F, 1'b0, 1'b1);
    test_full_run();
    test_back_to_back();
    test_reset_mid_run();
`ifdef LBIST_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lbist_ctrl_c432.md
Name: lbist_ctrl_c432

Overview:
- Logic-BIST controller for the c432 36-input / 7-output combinational CUT.
- Generates pseudo-random patterns with a 36-bit LFSR and drives them onto the CUT inputs.
- Compacts the CUT responses into a 16-bit MISR over a programmed pattern count, then compares the result against a golden signature.
- Sits between the test-access/top-level sequencer and the CUT wrapper.

Parameters:
- PAT_COUNT, 1024: patterns applied per session; legal range 1..65535.
- LFSR_SEED, 36'h0_0000_0001: LFSR load value. A zero value is replaced by 36'h1.
- MISR_POLY, 16'h002D: Galois MISR feedback polynomial (x^16+x^5+x^3+x^2+1).
- GOLDEN_SIG, 16'h0000: expected final signature.

Ports:
- clk  in  1  system clock, all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- cut_in  out  36  pattern to CUT inputs, bit0 maps to N1 … bit35 maps to N115.
- cut_out  in  7  CUT responses, bit0 maps to N223 … bit6 maps to N432.
- busy  out  1  high in INIT, RUN and COMPARE.
- done  out  1  high in DONE, held until the next start.
- pass  out  1  valid while done=1.
- signature  out  16  MISR contents; final value is frozen in DONE.
- pat_cnt  out  16  number of patterns applied so far.

Behaviour:
- Reset:
  - State = IDLE; lfsr = LFSR_SEED (zero replaced by 1); misr = 0; pat_cnt = 0.
  - busy = 0, done = 0, pass = 0, cut_in = 0.
- States and transitions:
  - IDLE: start → INIT.
  - INIT, one cycle: lfsr ← seed, misr ← 0, pat_cnt ← 0 → RUN.
  - RUN: each cycle
    - cut_in = lfsr, driven combinationally from the register.
    - misr ← {misr[14:0],1'b0} ^ (misr[15] ? MISR_POLY : 0) ^ {9'b0, cut_out}.
    - lfsr ← {lfsr[34:0], lfsr[35]^lfsr[24]}.
    - pat_cnt ← pat_cnt + 1.
    - Exit to COMPARE on the cycle where pat_cnt == PAT_COUNT-1; that cycle's response is still absorbed.
  - COMPARE, one cycle: pass ← (misr == GOLDEN_SIG) → DONE.
  - DONE: done = 1; signature and pass are held.
    - start → INIT (restart). done and pass clear on entry to INIT.
- Outputs and timing:
  - cut_in = 0 in every state other than RUN.
  - CUT is combinational, so cut_out is sampled in the same cycle as the cut_in it responds to.
  - Latency: start accepted at edge 0; INIT occupies cycle 1; RUN occupies cycles 2..PAT_COUNT+1; COMPARE at PAT_COUNT+2; done=1 from PAT_COUNT+3.
- Boundary conditions:
  - start during INIT, RUN or COMPARE is ignored.
  - PAT_COUNT=1: RUN lasts exactly one cycle.
  - pat_cnt never wraps; the terminal compare prevents overflow.
  - LFSR never reaches the all-zero state.
  - rst_n asserted mid-session: immediate return to reset values; no partial signature is retained.

Optional Feature:
- Macro: LBIST_ABORT_EN.
- Defined:
  - Adds input `abort` (1 bit).
  - abort=1 in INIT, RUN or COMPARE → DONE next cycle with pass=0. signature holds its current value; pat_cnt holds the count reached.
  - abort has priority over the normal RUN→COMPARE exit.
- Undefined: no `abort` port; sessions always run to completion.

Decomposition:
- Package lbist_pkg:
  - state enum {IDLE, INIT, RUN, COMPARE, DONE}.
  - Constants: CUT_IN_W=36, CUT_OUT_W=7, MISR_W=16, LFSR tap indices 35/24, default MISR_POLY.
- Sub-module lbist_misr:
  - Parameterized width/poly; inputs clr, en, data; output sig.
  - Instantiated once.
  - LFSR and FSM stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with start=1 → all outputs 0, state IDLE; after release, no activity until a start pulse.
- PAT_COUNT=4, seed=1, cut_out tied 7'h00 → cut_in sequence 1,2,4,8 in RUN cycles 2..5; signature=16'h0000; pass=1 with GOLDEN_SIG=0; done rises at cycle 7.
- PAT_COUNT=4, cut_out tied 7'h01 → misr sequence 1,3,7,F; signature=16'h000F; pass=0 for GOLDEN_SIG=0 and pass=1 for GOLDEN_SIG=16'h000F.
- Real CUT, PAT_COUNT=1024, run twice back-to-back via start in DONE → identical signatures; second run clears done/pass at INIT; pat_cnt=1024 at done.
- Mid-RUN rst_n pulse at pattern 10 → outputs return to reset values immediately; a new start yields the full-run signature.
- With LBIST_ABORT_EN: abort at pat_cnt=5 → done next cycle, pass=0, pat_cnt=5 held.
